spi_xfer_adc: RTL

- Parametrised full-duplex SPI master for the ADC/DAC command path. It generalises the fixed 8-bit write-only engine with the following:
  - configurable frame width and divider width
  - all four CPOL/CPHA modes
  - MISO capture into a readback register
  - busy/done handshake
- Sits between the measurement sequencer (strobe, command word, divider value) and the converter pins.

---
 rtl/spi_xfer_adc.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spi_xfer_adc.sv
// rtl/spi_xfer_adc.sv - parametrised full-duplex SPI master (all CPOL/CPHA modes) for the ADC/DAC command path
module spi_xfer_adc #(
  parameter int Width    = 8,
  parameter int DivWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                strw_i,
  input  logic [Width-1:0]    cmd_i,
  input  logic [DivWidth-1:0] kmax_i,
  input  logic                cpol_i,
  input  logic                cpha_i,
  input  logic                miso_i,
  output logic                mosi_o,
  output logic                dclk_o,
  output logic                cs_o,
  output logic                busy_o,
  output logic                eow_o,
  output logic [Width-1:0]    rdata_o,
  output logic                slow_clk_o
);

  localparam int EW = $clog2(2*Width+1);
  localparam logic [EW-1:0] ELAST = EW'(2*Width);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t              state;
  logic [DivWidth-1:0] kmax_lat;
  logic [DivWidth-1:0] div_cnt;
  logic                cpol_lat;
  logic                cpha_lat;
  logic [Width-1:0]    tx_sh;
  logic [Width-1:0]    rx_sh;
  logic [EW-1:0]       edge_cnt;
  logic [EW-1:0]       edge_nxt;
  logic                tick;

  // The divider only runs in the three timed states; each tick ends one dclk half-period.
  assign tick       = ((state == SETUP) || (state == SHIFT) || (state == HOLD)) && (div_cnt == kmax_lat);
  assign slow_clk_o = tick;
  assign edge_nxt   = edge_cnt + EW'(1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      kmax_lat <= '0;
      div_cnt  <= '0;
      cpol_lat <= 1'b0;
      cpha_lat <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      mosi_o   <= 1'b0;
      dclk_o   <= 1'b0;
      cs_o     <= 1'b1;
      busy_o   <= 1'b0;
      eow_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      eow_o <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          dclk_o  <= cpol_lat;
          if (strw_i) begin
            kmax_lat <= kmax_i;
            cpol_lat <= cpol_i;
            cpha_lat <= cpha_i;
            dclk_o   <= cpol_i;
            cs_o     <= 1'b0;
            busy_o   <= 1'b1;
            edge_cnt <= '0;
            rx_sh    <= '0;
            // With cpha=0 the first bit must be on the line before the first (sampling) edge.
            if (!cpha_i) begin
              mosi_o <= cmd_i[Width-1];
              tx_sh  <= cmd_i << 1;
            end else begin
              mosi_o <= 1'b0;
              tx_sh  <= cmd_i;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            div_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DivWidth'(1);
          end
        end
        SHIFT: begin
          if (tick) begin
            div_cnt  <= '0;
            dclk_o   <= ~dclk_o;
            edge_cnt <= edge_nxt;
            // Odd edges sample when cpha=0, even edges sample when cpha=1; the other edge drives.
            if (edge_nxt[0] ^ cpha_lat) begin
              rx_sh <= {rx_sh[Width-2:0], miso_i};
            end else if (edge_nxt != ELAST) begin
              mosi_o <= tx_sh[Width-1];
              tx_sh  <= tx_sh << 1;
            end
            if (edge_nxt == ELAST) begin
              state <= HOLD;
            end
          end else begin
            div_cnt <= div_cnt + DivWidth'(1);
          end
        end
        HOLD: begin
          if (tick) begin
            div_cnt <= '0;
            eow_o   <= 1'b1;
            rdata_o <= rx_sh;
            cs_o    <= 1'b1;
            mosi_o  <= 1'b0;
            state   <= DONE;
          end else begin
            div_cnt <= div_cnt + DivWidth'(1);
          end
        end
        DONE: begin
          div_cnt <= '0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
